// File: rtl/sr_seq_pkg.sv
// rtl/sr_seq_pkg.sv - shared types and constants for the shift-register scan sequencer
package sr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_LOAD = 3'd2,
        ST_GAP       = 3'd3,
        ST_FINISH    = 3'd4
    } sr_state_t;

    localparam int DEF_TIMEOUT_CYC = 1023;

    function automatic int calc_nwords(input int width, input int word_width);
        return (width + word_width - 1) / word_width;
    endfunction

endpackage

// File: rtl/sr_cfg_assembler.sv
// rtl/sr_cfg_assembler.sv - assembles the parallel configuration word from word-wide writes
module sr_cfg_assembler
    import sr_seq_pkg::*;
#(
    parameter int WIDTH      = 170,
    parameter int WORD_WIDTH = 32,
    parameter int NWORDS     = calc_nwords(WIDTH, WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  idle,
    input  logic                  cfg_wr,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_clr,
    input  logic                  go_err,
    output logic [WIDTH-1:0]      sr_din,
    output logic [3:0]            word_cnt,
    output logic                  err_cfg,
    output logic                  full
);

    // Bits shifted past WIDTH are never visible, so only WIDTH bits are stored.
    logic [WIDTH-1:0] asm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q    <= '0;
            word_cnt <= '0;
            err_cfg  <= 1'b0;
        end else if (idle && cfg_clr) begin
            asm_q    <= '0;
            word_cnt <= '0;
            err_cfg  <= 1'b0;
        end else begin
            if (idle && cfg_wr) begin
                asm_q <= {asm_q[WIDTH-WORD_WIDTH-1:0], cfg_data};
                if (!full)
                    word_cnt <= word_cnt + 4'd1;
            end
            if ((cfg_wr && !idle) || go_err)
                err_cfg <= 1'b1;
        end
    end

    assign sr_din = asm_q;
    assign full   = (word_cnt == 4'(NWORDS));

endmodule

// File: rtl/sr_scan_sequencer.sv
// rtl/sr_scan_sequencer.sv - start/load/gap sequencing of the shift-register datapath
module sr_scan_sequencer
    import sr_seq_pkg::*;
#(
    parameter int WIDTH       = 170,
    parameter int WORD_WIDTH  = 32,
    parameter int NWORDS      = calc_nwords(WIDTH, WORD_WIDTH),
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int TMO_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_wr,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_clr,
    input  logic                  go,
    input  logic                  abort,
    input  logic [15:0]           repeat_num,
    input  logic [15:0]           gap_cycles,
    input  logic                  sr_load,
    input  logic                  fifo_full,
    output logic                  sr_start,
    output logic [WIDTH-1:0]      sr_din,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic                  err_cfg,
    output logic [3:0]            word_cnt,
    output logic [15:0]           pass_cnt
);

    sr_state_t            state, state_nx;
    logic                 sr_load_q;
    logic                 load_evt;
    logic                 cfg_full;
    logic                 go_ok, go_err;
    logic                 gap_done;
    logic                 tmo_hit;
    logic [15:0]          remaining;
    logic [15:0]          gap_lat;
    logic [15:0]          gap_cnt;
    logic [TMO_WIDTH-1:0] tmo_cnt;

    assign busy     = (state != ST_IDLE);
    assign load_evt = sr_load & ~sr_load_q;
    assign go_ok    = (state == ST_IDLE) && go && cfg_full;
    assign go_err   = (state == ST_IDLE) && go && !cfg_full;
    // gap_cnt counts GAP cycles already spent; widened so it cannot wrap.
    assign gap_done = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, gap_lat};
    assign tmo_hit  = (tmo_cnt == TMO_WIDTH'(TIMEOUT_CYC - 1));

    sr_cfg_assembler #(
        .WIDTH      (WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .NWORDS     (NWORDS)
    ) u_cfg (
        .clk      (clk),
        .rst_n    (rst_n),
        .idle     (state == ST_IDLE),
        .cfg_wr   (cfg_wr),
        .cfg_data (cfg_data),
        .cfg_clr  (cfg_clr),
        .go_err   (go_err),
        .sr_din   (sr_din),
        .word_cnt (word_cnt),
        .err_cfg  (err_cfg),
        .full     (cfg_full)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (go_ok) state_nx = ST_START;
            ST_START:     state_nx = ST_WAIT_LOAD;
            ST_WAIT_LOAD: begin
                if (load_evt) begin
                    if (remaining == 16'd1)
                        state_nx = ST_FINISH;
                    else if (gap_lat == 16'd0 && !fifo_full)
                        state_nx = ST_START;
                    else
                        state_nx = ST_GAP;
                end else if (tmo_hit) begin
                    state_nx = ST_FINISH;
                end
            end
            ST_GAP:       if (gap_done && !fifo_full) state_nx = ST_START;
            ST_FINISH:    state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE && state != ST_FINISH)
            state_nx = ST_FINISH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sr_load_q   <= 1'b0;
            sr_start    <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            pass_cnt    <= '0;
            remaining   <= '0;
            gap_lat     <= '0;
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
        end else begin
            state     <= state_nx;
            sr_load_q <= sr_load;
            sr_start  <= (state_nx == ST_START);
            done      <= (state == ST_FINISH);
            case (state)
                ST_IDLE: begin
                    if (go_ok) begin
                        remaining   <= (repeat_num == 16'd0) ? 16'd1 : repeat_num;
                        gap_lat     <= gap_cycles;
                        pass_cnt    <= '0;
                        err_timeout <= 1'b0;
                    end
                end
                ST_START: tmo_cnt <= '0;
                ST_WAIT_LOAD: begin
                    // A load in the timeout cycle still counts as a completed pass.
                    if (!abort) begin
                        if (load_evt) begin
                            pass_cnt  <= pass_cnt + 16'd1;
                            remaining <= remaining - 16'd1;
                            gap_cnt   <= '0;
                        end else if (tmo_hit) begin
                            err_timeout <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                ST_GAP: if (!gap_done) gap_cnt <= gap_cnt + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sr_scan_sequencer.md
Name: sr_scan_sequencer

Overview:
- Sequences the TMIIa shift-register write/readback datapath.
- Assembles a WIDTH-bit configuration word from 32-bit control-interface writes and presents it as the datapath's parallel input.
- On command, issues start pulses to the datapath and waits for load completion, with timeout.
- Inserts a programmable gap that is back-pressured by the readback FIFO's full flag, repeats for a programmed pass count, and reports busy/done/error status.

Parameters:
- WIDTH, 170, shift-register length in bits; width of sr_din.
- WORD_WIDTH, 32, control-interface write width.
- NWORDS, 6, number of writes to fill sr_din; equals ceil(WIDTH/WORD_WIDTH).
- TIMEOUT_CYC, 1023, maximum cycles allowed in WAIT_LOAD.
- TMO_WIDTH, 10, timeout counter width; 2**TMO_WIDTH-1 >= TIMEOUT_CYC.

Ports:
- clk  in  1  divided SR control clock, shared with the datapath.
- rst_n  in  1  asynchronous reset, active low.
- cfg_wr  in  1  single-cycle write strobe.
- cfg_data  in  WORD_WIDTH  config word.
- cfg_clr  in  1  clears the assembly register and word count.
- go  in  1  start-sequence request, level sampled.
- abort  in  1  stop the sequence and return to IDLE.
- repeat_num  in  16  number of passes; 0 is treated as 1.
- gap_cycles  in  16  idle cycles between passes.
- sr_load  in  1  load strobe from the datapath.
- fifo_full  in  1  readback FIFO full flag.
- sr_start  out  1  start pulse to the datapath.
- sr_din  out  WIDTH  parallel config word to the datapath.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at sequence end.
- err_timeout  out  1  sticky; cleared on the next accepted go.
- err_cfg  out  1  sticky; cleared by cfg_clr.
- word_cnt  out  4  number of accepted writes, saturating at NWORDS.
- pass_cnt  out  16  passes completed in the current or last sequence.

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0, the assembly register is 0, and state is IDLE.
- Assembly register: NWORDS*WORD_WIDTH bits (192 with defaults).
  - On cfg_wr in IDLE: shift left by WORD_WIDTH and insert cfg_data at the LSBs.
  - sr_din is the low WIDTH bits of the register, so the first write ends up most significant and upper excess bits are dropped.
  - word_cnt increments on each accepted write and saturates at NWORDS; further writes still shift.
- Rejected writes: cfg_wr while busy is ignored and sets err_cfg.
- cfg_clr (IDLE only; ignored while busy): zeroes the register and word_cnt, clears err_cfg, and has priority over a simultaneous cfg_wr.
- go acceptance: accepted only in IDLE with word_cnt == NWORDS. go with an incomplete word sets err_cfg and the FSM stays in IDLE.
- Acceptance latches (repeat_num==0 ? 1 : repeat_num) into remaining, latches gap_cycles, clears pass_cnt and err_timeout, and moves to START.
- sr_load edge detection: sr_load is registered and a rising edge (sr_load & ~sr_load_q) is the load event. Edges seen outside WAIT_LOAD are ignored.
- FSM states:
  - IDLE: as above.
  - START: sr_start=1 for exactly one cycle, timeout counter cleared, then WAIT_LOAD. sr_start is registered, so it is high the cycle after go is sampled.
  - WAIT_LOAD:
    - Load event: pass_cnt+1, remaining-1; if remaining was 1 go to FINISH, else GAP.
    - Counter reaches TIMEOUT_CYC first: set err_timeout and go to FINISH.
    - Load event in the same cycle as the timeout: the load wins.
  - GAP: counter counts gap_cycles cycles (gap 0 means zero cycles). When the count is complete and fifo_full is 0, go to START; while fifo_full is 1, hold in GAP indefinitely.
  - FINISH: done=1 for one cycle, then IDLE.
- Pass spacing: minimum is 1 (START) + load latency + gap + 0.
- abort: from any non-IDLE state, go to FINISH next cycle. This produces a done pulse, no sr_start, and no err_timeout change. abort in START still lets that cycle's sr_start issue.
- Counters: pass_cnt wraps modulo 2^16 (unreachable, since it is capped by repeat_num). remaining and the gap counter are 16-bit unsigned.
- sr_din is held stable while busy.

Decomposition:
- Shared package sr_seq_pkg holds:
  - state encoding localparams (IDLE, START, WAIT_LOAD, GAP, FINISH);
  - NWORDS computation;
  - the default TIMEOUT_CYC.
- Natural sub-module: sr_cfg_assembler (assembly register, word_cnt, cfg_clr/err_cfg logic). The FSM, counters and edge detection stay in the top module.

Test Plan:
- Reset and assembly: reset, then 6 writes 0x00000001..0x00000006.
  - Required: word_cnt=6; sr_din[31:0]=0x6, sr_din[63:32]=0x5, sr_din[169:160] = low 10 bits of 0x1; all outputs 0 during reset.
- Single pass: go with repeat_num=0 and sr_load rising 180 cycles after sr_start.
  - Required: exactly one sr_start pulse; done one cycle after FINISH entry; pass_cnt=1; busy low afterwards.
- Repeats with back-pressure: repeat_num=3, gap_cycles=4, fifo_full high for 10 cycles during the second gap.
  - Required: 3 sr_start pulses; first gap start-to-start = 1+load latency+4; second gap extended by the fifo_full hold; pass_cnt=3.
- Timeout: go, sr_load never rises.
  - Required: err_timeout set after 1023 WAIT_LOAD cycles; done pulse; next go clears err_timeout.
- Config errors: go with word_cnt=5, then cfg_wr while busy.
  - Required: no sr_start and err_cfg=1 after the first; sr_din unchanged and err_cfg=1 after the second; cfg_clr clears word_cnt and err_cfg.
- Abort and reset mid-run: abort in GAP of a 5-pass run, then rst_n low in WAIT_LOAD.
  - Required: done next-but-one cycle, pass_cnt frozen at its current value; after reset all outputs 0 and state IDLE.
